// File: rtl/latch_wr_ctrl.sv
// Write-timing controller for a bank of gated D latches: drives d with
// guaranteed setup / pulse / hold intervals around a glitch-free enable e.
module latch_wr_ctrl #(
  parameter int WIDTH   = 8,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 2,
  parameter int T_HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             e,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done
);

  localparam int MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int MAX_T  = (MAX_SP > T_HOLD) ? MAX_SP : T_HOLD;
  localparam int CW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            accept;
  logic            seq_end;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    seq_end   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = CW'(T_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = ENABLE;
          cnt_nxt   = CW'(T_PULSE - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ENABLE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = CW'(T_HOLD - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          seq_end   = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and the update order cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      e     <= 1'b0;
      d     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // e decoded from the next state keeps it a clean register output
      e     <= (state_nxt == ENABLE);
      done  <= seq_end;
      if (accept) d <= in_data;
    end
  end

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// Self-checking bench: two controller instances (default and swept timing)
// share one randomized stimulus and are compared against a timeline model.
module tb_latch_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;

  logic       ready_a, e_a, busy_a, done_a;
  logic [7:0] d_a;
  logic       ready_b, e_b, busy_b, done_b;
  logic [7:0] d_b;

  always #5 clk = ~clk;

  latch_wr_ctrl #(.WIDTH(8), .T_SETUP(2), .T_PULSE(2), .T_HOLD(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
    .in_data(in_data), .e(e_a), .d(d_a), .busy(busy_a), .done(done_a)
  );

  latch_wr_ctrl #(.WIDTH(8), .T_SETUP(1), .T_PULSE(3), .T_HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b),
    .in_data(in_data), .e(e_b), .d(d_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: a write is "accept edge + elapsed cycles"; the outputs
  // follow directly from where elapsed falls against the three intervals.
  int         ts [2] = '{2, 1};
  int         tp [2] = '{2, 3};
  int         th [2] = '{1, 2};
  bit         m_active  [2];
  int         m_elapsed [2];
  logic [7:0] m_d       [2];
  bit         m_done    [2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_active[k] = 1'b0;
        m_d[k]      = 8'h00;
        m_done[k]   = 1'b0;
      end else begin
        m_done[k] = 1'b0;
        if (!m_active[k]) begin
          if (in_valid) begin
            m_active[k]  = 1'b1;
            m_elapsed[k] = 0;
            m_d[k]       = in_data;
          end
        end else begin
          m_elapsed[k]++;
          if (m_elapsed[k] == ts[k] + tp[k] + th[k]) begin
            m_active[k] = 1'b0;
            m_done[k]   = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic exp_e(input int k);
    return m_active[k] && (m_elapsed[k] >= ts[k]) && (m_elapsed[k] < ts[k] + tp[k]);
  endfunction

  task automatic compare_all();
    check("a.e",        32'(e_a),     32'(exp_e(0)));
    check("a.d",        32'(d_a),     32'(m_d[0]));
    check("a.busy",     32'(busy_a),  32'(m_active[0]));
    check("a.done",     32'(done_a),  32'(m_done[0]));
    check("a.in_ready", 32'(ready_a), 32'(!m_active[0] && !rst));
    check("b.e",        32'(e_b),     32'(exp_e(1)));
    check("b.d",        32'(d_b),     32'(m_d[1]));
    check("b.busy",     32'(busy_b),  32'(m_active[1]));
    check("b.done",     32'(done_b),  32'(m_done[1]));
    check("b.in_ready", 32'(ready_b), 32'(!m_active[1] && !rst));
  endtask

  // One clock cycle: drive inputs, let the edge happen, sample at negedge.
  task automatic step(input logic r, input logic v, input logic [7:0] dat);
    rst      = r;
    in_valid = v;
    in_data  = dat;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // reset held three cycles, then idle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00);

    // single write of A5
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'($urandom));

    // back-to-back: valid held high, A5 then 3C
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00);

    // busy-time noise on in_valid / in_data after an A5 accept
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom), 8'($urandom));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00);

    // all-ones word
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00);

    // reset during ENABLE, then a clean write of 11
    step(1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h77);
    check("abort.e", 32'(e_a), 32'h0);
    check("abort.d", 32'(d_a), 32'h0);
    step(1'b0, 1'b1, 8'h11);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0), 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
